regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with write-forwarding and a per-register busy scoreboard. It replaces the fixed 32x32 two-read/one-write file in the CPU datapath. It adds configurable width, depth and read-port count, a second write port for a dual-writeback pipeline, and busy tracking so the issue stage can stall on in-flight producers.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and allocs
- BYPASS, 1, when 1, same-cycle writes are forwarded to reads
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy_o  out  NUM_RD  busy flag of each read address
- wr0_en_i / wr0_addr_i / wr0_data_i  in  1 / ADDR_W / DATA_W  write port 0
- wr1_en_i / wr1_addr_i / wr1_data_i  in  1 / ADDR_W / DATA_W  write port 1
- alloc_en_i  in  1  mark a destination register busy (issue of a producer)
- alloc_addr_i  in  ADDR_W  register to mark busy
- busy_vec_o  out  DEPTH  registered busy bit of every register

## Operation
- Storage: DEPTH x DATA_W flops plus a DEPTH-bit busy vector.
- Reset (rst high, asynchronous): all registers are 0 and all busy bits are 0.
  - While reset is held: rd_data_o shows 0 except through bypass (which is still gated by ZERO_REG); busy_vec_o and rd_busy_o are 0.
- Write: at the clock edge, when wrN_en_i is set, reg[wrN_addr_i] takes wrN_data_i.
  - Both ports on the same address: port 1 wins.
  - With ZERO_REG=1, address 0 is never written.
- Read: rd_data_o[k] is combinational from rd_addr_i[k].
  - With BYPASS=1, a same-cycle write hit is forwarded. Priority is wr1, then wr0, then storage.
  - With ZERO_REG=1 and address 0, the output is 0 regardless of writes.
- Busy scoreboard, per register r, next state:
  - alloc_en_i && alloc_addr_i==r: busy[r] is set. Alloc has priority over a same-cycle write to r, because the new producer supersedes the completing one.
  - Otherwise, a write to r on either port clears busy[r].
  - Otherwise, busy[r] holds.
  - With ZERO_REG=1, busy[0] is constant 0.
- rd_busy_o[k]:
  - Default: busy[rd_addr_i[k]].
  - With BYPASS=1, it is forced to 0 when a same-cycle write hits rd_addr_i[k], since the data is forwarded. Exception: if alloc_en_i targets the same address that cycle, rd_busy_o[k] is not forced low and reflects the registered busy bit.
  - With BYPASS=0, rd_busy_o[k] is the registered busy bit only.
- Alloc of a register that is already busy is legal and leaves it busy.
- A write to a register that is not busy is legal: data updates, busy stays 0.

## Timing
- Read data and rd_busy_o: 0-cycle combinational paths from addresses, and from write ports when BYPASS=1.
- Write data visible in storage: 1 cycle after the enabling edge.
- busy_vec_o: updated at the edge following alloc or write. No combinational path from inputs.
- Reset deassertion: state is usable from the first rising edge after rst falls.
- Reset asserted mid-operation: all state clears immediately. Writes and allocs in the same cycle are discarded.

## Test plan
- Reset: assert rst mid-run after writing reg 5 = 0x1234 -> rd_data_o for addr 5 is 0 and busy_vec_o = 0, without waiting for a clock edge.
- Write/read: wr0 reg 3 = 0xDEADBEEF, then read port 1 of addr 3 on the next cycle -> 0xDEADBEEF. Same-cycle read with BYPASS=1 -> 0xDEADBEEF. Same-cycle read with BYPASS=0 -> old value 0.
- Dual-write conflict: wr0 and wr1 both to reg 7, with data 0x11 and 0x22 -> stored value 0x22, and the same-cycle bypass read also returns 0x22.
- Zero register: wr0 and wr1 to reg 0 with 0xFFFFFFFF, plus alloc of reg 0 -> reads of 0 return 0; busy_vec_o[0] = 0.
- Scoreboard: alloc reg 9 -> busy_vec_o[9] = 1 next cycle; wr1 reg 9 = 0x55 -> same-cycle rd_busy_o = 0 with data 0x55, and busy_vec_o[9] = 0 next cycle.
- Alloc/write race: with reg 9 busy, alloc reg 9 and write reg 9 in the same cycle -> busy_vec_o[9] stays 1, data updated. Parametrisation run (DATA_W=64, ADDR_W=6, NUM_RD=4) -> all four read ports of reg 63 return the written 64-bit value.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two write ports,
// same-cycle write forwarding and a per-register busy scoreboard used by the
// issue stage to stall on in-flight producers.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr0_en_i,
    input  logic [ADDR_W-1:0]        wr0_addr_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr1_en_i,
    input  logic [ADDR_W-1:0]        wr1_addr_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    output logic [(2**ADDR_W)-1:0]   busy_vec_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // True when the address is the hardwired zero register of this instance.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Write enables with the zero register masked out; every consumer
    // (storage, scoreboard, forwarding) uses these qualified versions.
    logic wr0_ok_s;
    logic wr1_ok_s;

    assign wr0_ok_s = wr0_en_i && !is_zero_reg(wr0_addr_i);
    assign wr1_ok_s = wr1_en_i && !is_zero_reg(wr1_addr_i);

    // Next-state storage: port 0 applied first so port 1 wins on a collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0_ok_s) begin
            regs_d[wr0_addr_i] = wr0_data_i;
        end else begin
            regs_d[wr0_addr_i] = regs_q[wr0_addr_i];
        end
        if (wr1_ok_s) begin
            regs_d[wr1_addr_i] = wr1_data_i;
        end else begin
            regs_d[wr1_addr_i] = regs_d[wr1_addr_i];
        end
    end

    // Next-state scoreboard: alloc beats a completing write because the newly
    // issued producer supersedes the one that is writing back.
    always_comb begin
        busy_d = {DEPTH{1'b0}};
        for (int r = 0; r < DEPTH; r++) begin
            if (is_zero_reg(ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end else if (alloc_en_i && (alloc_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wr0_ok_s && (wr0_addr_i == ADDR_W'(r))) ||
                         (wr1_ok_s && (wr1_addr_i == ADDR_W'(r)))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // State registers; asynchronous reset clears data and busy immediately
    // and discards any write or alloc presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= {DATA_W{1'b0}};
            end
            busy_q <= {DEPTH{1'b0}};
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    // Read ports: each port is an independent combinational mux.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              hit0_s;
        logic              hit1_s;
        logic              alloc_hit_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s      = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign hit0_s      = (BYPASS != 0) && wr0_ok_s && (wr0_addr_i == addr_s);
        assign hit1_s      = (BYPASS != 0) && wr1_ok_s && (wr1_addr_i == addr_s);
        assign alloc_hit_s = alloc_en_i && (alloc_addr_i == addr_s);

        // Data select: zero register, then wr1, then wr0, then storage.
        always_comb begin
            data_s = {DATA_W{1'b0}};
            if (is_zero_reg(addr_s)) begin
                data_s = {DATA_W{1'b0}};
            end else if (hit1_s) begin
                data_s = wr1_data_i;
            end else if (hit0_s) begin
                data_s = wr0_data_i;
            end else begin
                data_s = regs_q[addr_s];
            end
        end

        // Busy select: a forwarded write hides the busy bit unless a new
        // producer is being allocated to the same register this cycle.
        always_comb begin
            busy_s = 1'b0;
            if ((hit0_s || hit1_s) && !alloc_hit_s) begin
                busy_s = 1'b0;
            end else begin
                busy_s = busy_q[addr_s];
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data_s;
        assign rd_busy_o[k]                  = busy_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: default instance (bypass on), a
// no-bypass instance sharing the same stimulus, and a wide 64x64 4-read one.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Stimulus shared by the default and no-bypass instances.
    logic [9:0]  rd_addr;
    logic        wr0_en, wr1_en, alloc_en;
    logic [4:0]  wr0_addr, wr1_addr, alloc_addr;
    logic [31:0] wr0_data, wr1_data;

    logic [63:0] rd_data_bp, rd_data_nb;
    logic [1:0]  rd_busy_bp, rd_busy_nb;
    logic [31:0] busy_bp, busy_nb;

    // Wide instance stimulus/outputs.
    logic [23:0]  w_rd_addr;
    logic         w_wr0_en, w_wr1_en, w_alloc_en;
    logic [5:0]   w_wr0_addr, w_wr1_addr, w_alloc_addr;
    logic [63:0]  w_wr0_data, w_wr1_data;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic [63:0]  w_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_bp), .rd_busy_o(rd_busy_bp),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(busy_bp));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(busy_nb));

    regfile_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_w (
        .clk(clk), .rst(rst), .rd_addr_i(w_rd_addr), .rd_data_o(w_rd_data), .rd_busy_o(w_rd_busy),
        .wr0_en_i(w_wr0_en), .wr0_addr_i(w_wr0_addr), .wr0_data_i(w_wr0_data),
        .wr1_en_i(w_wr1_en), .wr1_addr_i(w_wr1_addr), .wr1_data_i(w_wr1_data),
        .alloc_en_i(w_alloc_en), .alloc_addr_i(w_alloc_addr), .busy_vec_o(w_busy));

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Return the default-width bus to idle (no writes, no alloc).
    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; alloc_en = 1'b0;
        wr0_addr = 5'd0; wr1_addr = 5'd0; alloc_addr = 5'd0;
        wr0_data = 32'd0; wr1_data = 32'd0;
    endtask

    // Advance past the next rising edge into the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rd_addr = 10'd0;
        w_wr0_en = 1'b0; w_wr1_en = 1'b0; w_alloc_en = 1'b0;
        w_wr0_addr = 6'd0; w_wr1_addr = 6'd0; w_alloc_addr = 6'd0;
        w_wr0_data = 64'd0; w_wr1_data = 64'd0; w_rd_addr = 24'd0;

        // Reset state.
        #3;
        rd_addr = {5'd3, 5'd5};
        #1;
        chk("rst_busy_vec", {32'd0, busy_bp}, 64'd0);
        chk("rst_rd_data", rd_data_bp, 64'd0);
        chk("rst_rd_busy", {62'd0, rd_busy_bp}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Write reg 5 = 0x1234 and allocate reg 6, then reset asynchronously.
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234;
        alloc_en = 1'b1; alloc_addr = 5'd6;
        step();
        idle();
        rd_addr = {5'd6, 5'd5};
        @(negedge clk);
        chk("pre_rst_data5", {32'd0, rd_data_bp[31:0]}, 64'h1234);
        chk("pre_rst_busy_vec", {32'd0, busy_bp}, 64'h40);
        chk("pre_rst_rd_busy6", {63'd0, rd_busy_bp[1]}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_data5", {32'd0, rd_data_bp[31:0]}, 64'd0);
        chk("mid_rst_busy_vec", {32'd0, busy_bp}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // wr0 reg 3 = DEADBEEF; same-cycle read on port 1.
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hDEADBEEF;
        rd_addr = {5'd3, 5'd0};
        @(negedge clk);
        chk("byp_rd3", {32'd0, rd_data_bp[63:32]}, 64'hDEADBEEF);
        chk("nobyp_rd3", {32'd0, rd_data_nb[63:32]}, 64'd0);
        step();
        idle();
        @(negedge clk);
        chk("stored_rd3_bp", {32'd0, rd_data_bp[63:32]}, 64'hDEADBEEF);
        chk("stored_rd3_nb", {32'd0, rd_data_nb[63:32]}, 64'hDEADBEEF);
        chk("wr_notbusy_vec", {32'd0, busy_bp}, 64'd0);

        // Dual write conflict on reg 7.
        step();
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        rd_addr = {5'd3, 5'd7};
        @(negedge clk);
        chk("dual_byp_rd7", {32'd0, rd_data_bp[31:0]}, 64'h22);
        chk("dual_nobyp_rd7", {32'd0, rd_data_nb[31:0]}, 64'd0);
        step();
        idle();
        @(negedge clk);
        chk("dual_stored_bp", {32'd0, rd_data_bp[31:0]}, 64'h22);
        chk("dual_stored_nb", {32'd0, rd_data_nb[31:0]}, 64'h22);

        // Zero register: writes and alloc ignored.
        step();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        chk("zero_byp_rd0", rd_data_bp, 64'd0);
        step();
        idle();
        @(negedge clk);
        chk("zero_stored_rd0", rd_data_bp, 64'd0);
        chk("zero_stored_rd0_nb", rd_data_nb, 64'd0);
        chk("zero_busy_vec", {32'd0, busy_bp}, 64'd0);

        // Scoreboard: alloc reg 9, then wr1 reg 9 completes it.
        step();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        step();
        idle();
        rd_addr = {5'd0, 5'd9};
        @(negedge clk);
        chk("sb_busy_vec", {32'd0, busy_bp}, 64'h200);
        chk("sb_rd_busy9", {63'd0, rd_busy_bp[0]}, 64'd1);
        step();
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h55;
        @(negedge clk);
        chk("sb_wr_rd_busy_bp", {63'd0, rd_busy_bp[0]}, 64'd0);
        chk("sb_wr_rd_data_bp", {32'd0, rd_data_bp[31:0]}, 64'h55);
        chk("sb_wr_rd_busy_nb", {63'd0, rd_busy_nb[0]}, 64'd1);
        step();
        idle();
        @(negedge clk);
        chk("sb_cleared_bp", {32'd0, busy_bp}, 64'd0);
        chk("sb_cleared_nb", {32'd0, busy_nb}, 64'd0);

        // Alloc/write race on an already busy reg 9.
        step();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        step();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hAA;
        @(negedge clk);
        chk("race_rd_busy", {63'd0, rd_busy_bp[0]}, 64'd1);
        chk("race_rd_data", {32'd0, rd_data_bp[31:0]}, 64'hAA);
        step();
        idle();
        @(negedge clk);
        chk("race_busy_vec", {32'd0, busy_bp}, 64'h200);
        chk("race_stored", {32'd0, rd_data_bp[31:0]}, 64'hAA);

        // Wide instance: reg 63 via wr0, reg 62 via wr1 in the same cycle.
        step();
        w_wr0_en = 1'b1; w_wr0_addr = 6'd63; w_wr0_data = 64'h0123456789ABCDEF;
        w_wr1_en = 1'b1; w_wr1_addr = 6'd62; w_wr1_data = 64'hFEDCBA9876543210;
        step();
        w_wr0_en = 1'b0; w_wr1_en = 1'b0;
        w_rd_addr = {6'd63, 6'd63, 6'd63, 6'd63};
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wide_rd63_p%0d", k), w_rd_data[k*64 +: 64], 64'h0123456789ABCDEF);
        end
        w_rd_addr = {6'd0, 6'd62, 6'd1, 6'd63};
        #1;
        chk("wide_rd62_p2", w_rd_data[128 +: 64], 64'hFEDCBA9876543210);
        chk("wide_rd1_p1", w_rd_data[64 +: 64], 64'd0);
        chk("wide_busy_vec", w_busy, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
